// File: rtl/cnt_fnd_pkg.sv
// Shared definitions for the loop-count FND driver: converter states,
// segment patterns (active-low {g,f,e,d,c,b,a}) and digit enables.
package cnt_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam int BCD_W = 12;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_DIG0 = 3'b110;
  localparam logic [2:0] AN_DIG1 = 3'b101;
  localparam logic [2:0] AN_DIG2 = 3'b011;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Bit-serial shift-add-3 binary to 3-digit BCD converter. Starts a new
// conversion whenever the input differs from the last converted value.
module bin2bcd_seq
  import cnt_fnd_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] bin,
  output logic [11:0]      bcd,
  output logic             busy
);

  localparam int IT_W = $clog2(CNT_W + 1);
  localparam int WK_W = BCD_W + CNT_W;
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(CNT_W - 1);

  conv_state_t r_state;
  conv_state_t w_state_next;

  // Working register is {bcd accumulator, remaining binary bits}
  logic [WK_W-1:0]  r_work;
  logic [WK_W-1:0]  w_adj;
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_lat;
  logic [IT_W-1:0]  r_iter;
  logic [11:0]      r_bcd;
  logic             r_busy;
  logic             w_capture;

  assign w_capture = (r_state == IDLE) && (bin != r_last);

  assign w_adj[CNT_W-1:0] = r_work[CNT_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      always_comb begin
        w_adj[CNT_W+gi*4 +: 4] = r_work[CNT_W+gi*4 +: 4];
        if (r_work[CNT_W+gi*4 +: 4] >= 4'd5)
          w_adj[CNT_W+gi*4 +: 4] = r_work[CNT_W+gi*4 +: 4] + 4'd3;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_state_next = CONV;
      CONV:    if (r_iter == LAST_IT) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_last <= '0;
      r_lat  <= '0;
      r_iter <= '0;
      r_bcd  <= '0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_work <= {{BCD_W{1'b0}}, bin};
            r_lat  <= bin;
            r_iter <= '0;
            r_busy <= 1'b1;
          end
        end
        CONV: begin
          r_work <= w_adj << 1;
          r_iter <= r_iter + IT_W'(1);
        end
        DONE: begin
          r_bcd  <= r_work[WK_W-1:CNT_W];
          r_last <= r_lat;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bcd  = r_bcd;
  assign busy = r_busy;

endmodule

// File: rtl/cnt_fnd_driver.sv
// Shows the loop count in decimal on a 3-digit common-anode FND: converter
// plus a time-multiplexed scanner with leading-zero blanking.
module cnt_fnd_driver
  import cnt_fnd_pkg::*;
#(
  parameter int CNT_W    = 7,
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [2:0]       an,
  output logic [11:0]      bcd,
  output logic             busy
);

  localparam int SC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);

  logic [11:0]     w_bcd;
  logic            w_busy;
  logic [SC_W-1:0] r_scan_cnt;
  logic [1:0]      r_digit;
  logic [2:0]      r_an;
  logic [6:0]      r_seg;
  logic            w_tick;
  logic [1:0]      w_digit_next;
  logic [3:0]      w_nib;
  logic [2:0]      w_an_next;
  logic            w_blank;
  logic [6:0]      w_seg_next;

  bin2bcd_seq #(
    .CNT_W(CNT_W)
  ) u_conv (
    .clk (clk),
    .rst (rst),
    .bin (cnt),
    .bcd (w_bcd),
    .busy(w_busy)
  );

  assign w_tick = (r_scan_cnt == SCAN_LAST);

  always_comb begin
    w_digit_next = r_digit;
    if (w_tick) w_digit_next = (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
  end

  // Decode for the digit that becomes active at this edge so seg and an
  // switch together.
  always_comb begin
    w_nib     = w_bcd[3:0];
    w_an_next = AN_DIG0;
    w_blank   = 1'b0;
    case (w_digit_next)
      2'd1: begin
        w_nib     = w_bcd[7:4];
        w_an_next = AN_DIG1;
        w_blank   = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib     = w_bcd[11:8];
        w_an_next = AN_DIG2;
        w_blank   = (w_bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
    w_seg_next = w_blank ? SEG_BLANK : seg_decode(w_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
      r_an       <= AN_DIG0;
      r_seg      <= SEG_0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SC_W'(1);
      r_digit    <= w_digit_next;
      r_an       <= w_an_next;
      r_seg      <= w_seg_next;
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign dp   = 1'b1;
  assign bcd  = w_bcd;
  assign busy = w_busy;

endmodule

// File: tb/tb_cnt_fnd_driver.sv
// Directed bench for cnt_fnd_driver with a fast scan (SCAN_DIV=4).
module tb_cnt_fnd_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cnt = 7'd0;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] an;
  logic [11:0] bcd;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cnt_fnd_driver #(
    .CNT_W   (7),
    .SCAN_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cnt (cnt),
    .seg (seg),
    .dp  (dp),
    .an  (an),
    .bcd (bcd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cnt = 7'd0;
    step(3);
    checks++;
    if (an !== 3'b110) begin errors++; $display("FAIL reset_an got=%b exp=110", an); end
    checks++;
    if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
    checks++;
    if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (busy !== 1'b0 || bcd !== 12'h000) begin
        errors++;
        $display("FAIL idle_after_reset busy=%b bcd=%h exp busy=0 bcd=000", busy, bcd);
      end
    end
    $display("test_reset: an=%b seg=%b bcd=%h busy=%b", an, seg, bcd, busy);
  endtask

  task automatic test_count_127;
    int n0, n1, n2;
    logic [6:0] exp_seg;
    cnt = 7'd127;
    step(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL c127_busy_E got=%b exp=1", busy); end
    step(7);
    checks++;
    if (busy !== 1'b1 || bcd !== 12'h000) begin
      errors++; $display("FAIL c127_E7 busy=%b bcd=%h exp busy=1 bcd=000", busy, bcd);
    end
    step(1);
    checks++;
    if (bcd !== 12'h127) begin errors++; $display("FAIL c127_bcd got=%h exp=127", bcd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL c127_busy_done got=%b exp=0", busy); end
    step(1);
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      case (an)
        3'b110:  begin exp_seg = 7'b1111000; n0++; end
        3'b101:  begin exp_seg = 7'b0100100; n1++; end
        3'b011:  begin exp_seg = 7'b1111001; n2++; end
        default: exp_seg = 7'bxxxxxxx;
      endcase
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL c127_scan an=%b seg=%b exp=%b", an, seg, exp_seg);
      end
    end
    checks++;
    if (n0 != 4 || n1 != 4 || n2 != 4) begin
      errors++; $display("FAIL c127_slots counts=%0d/%0d/%0d exp=4/4/4", n0, n1, n2);
    end
    $display("test_count_127: bcd=%h", bcd);
  endtask

  task automatic test_blank_5;
    logic [6:0] exp_seg;
    cnt = 7'd5;
    step(9);
    checks++;
    if (bcd !== 12'h005) begin errors++; $display("FAIL c5_bcd got=%h exp=005", bcd); end
    step(1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      case (an)
        3'b110:  exp_seg = 7'b0010010;
        3'b101:  exp_seg = 7'b1111111;
        3'b011:  exp_seg = 7'b1111111;
        default: exp_seg = 7'bxxxxxxx;
      endcase
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL c5_scan an=%b seg=%b exp=%b", an, seg, exp_seg);
      end
    end
    $display("test_blank_5: bcd=%h", bcd);
  endtask

  task automatic test_change_during_conv;
    cnt = 7'd100;
    step(3);
    cnt = 7'd42;
    step(5);
    checks++;
    if (busy !== 1'b1 || bcd !== 12'h005) begin
      errors++; $display("FAIL chg_E7 busy=%b bcd=%h exp busy=1 bcd=005", busy, bcd);
    end
    step(1);
    checks++;
    if (bcd !== 12'h100 || busy !== 1'b0) begin
      errors++; $display("FAIL chg_first busy=%b bcd=%h exp busy=0 bcd=100", busy, bcd);
    end
    step(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL chg_recapture busy=%b exp=1", busy); end
    step(7);
    checks++;
    if (bcd !== 12'h100) begin errors++; $display("FAIL chg_hold got=%h exp=100", bcd); end
    step(1);
    checks++;
    if (bcd !== 12'h042 || busy !== 1'b0) begin
      errors++; $display("FAIL chg_second busy=%b bcd=%h exp busy=0 bcd=042", busy, bcd);
    end
    $display("test_change_during_conv: bcd=%h", bcd);
  endtask

  task automatic test_reset_mid_conv;
    cnt = 7'd99;
    step(4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (bcd !== 12'h000 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_abort busy=%b bcd=%h exp busy=0 bcd=000", busy, bcd);
    end
    checks++;
    if (an !== 3'b110 || seg !== 7'b1000000) begin
      errors++; $display("FAIL rmid_disp an=%b seg=%b exp an=110 seg=1000000", an, seg);
    end
    step(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmid_restart busy=%b exp=1", busy); end
    step(7);
    checks++;
    if (bcd !== 12'h000) begin errors++; $display("FAIL rmid_hold got=%h exp=000", bcd); end
    step(1);
    checks++;
    if (bcd !== 12'h099) begin errors++; $display("FAIL rmid_bcd got=%h exp=099", bcd); end
    $display("test_reset_mid_conv: bcd=%h", bcd);
  endtask

  task automatic test_counter_sweep;
    int v;
    logic [11:0] exp_bcd;
    logic [6:0]  exp_seg;
    for (int s = 0; s <= 128; s++) begin
      v = s % 128;
      cnt = 7'(v);
      step(20);
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      checks++;
      if (bcd !== exp_bcd || busy !== 1'b0) begin
        errors++; $display("FAIL sweep_%0d bcd=%h busy=%b exp bcd=%h busy=0", v, bcd, busy, exp_bcd);
      end
      $display("sweep cnt=%0d bcd=%h", v, bcd);
    end
    for (int i = 0; i < 12; i++) begin
      step(1);
      case (an)
        3'b110:  exp_seg = 7'b1000000;
        3'b101:  exp_seg = 7'b1111111;
        3'b011:  exp_seg = 7'b1111111;
        default: exp_seg = 7'bxxxxxxx;
      endcase
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL wrap_scan an=%b seg=%b exp=%b", an, seg, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_127();
    test_blank_5();
    test_change_during_conv();
    test_reset_mid_conv();
    test_counter_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
